// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-tick divider, h/v counters, look-ahead framebuffer request
// and a two-stage pipeline that keeps sync and colour leaving the pins together.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int CLK_DIV  = 1,
  parameter int CW       = 11
) (
  input  logic          MAX10_CLK1_50,
  input  logic          reset_n,
  input  logic [1:0]    mode,
  output logic          pix_req,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  input  logic [11:0]   pix_rgb,
  output logic [3:0]    VGA_R,
  output logic [3:0]    VGA_G,
  output logic [3:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W   = H_ACTIVE / 8;

  // Bar colours, index 0 is the leftmost bar.
  localparam logic [7:0][11:0] BAR_RGB = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F, 12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  logic [DIV_W-1:0] div_reg, div_next;
  logic [CW-1:0]    hc_reg, hc_next;
  logic [CW-1:0]    vc_reg, vc_next;
  logic [1:0]       mode_reg;
  logic             pix_req_reg;
  logic [CW-1:0]    pix_x_reg, pix_y_reg;
  logic             hs1_reg, vs1_reg;
  logic             hs_reg, vs_reg;
  logic [11:0]      rgb_reg, rgb_next;
  logic             frame_start_reg;

  logic tick, h_last, v_last, at_origin;
  logic h_in_sync, v_in_sync, active;
  logic [7:0] bar_hit;

  always_comb begin
    tick      = (div_reg == DIV_W'(CLK_DIV - 1));
    div_next  = tick ? '0 : div_reg + 1'b1;
    h_last    = (hc_reg == CW'(H_TOTAL - 1));
    v_last    = (vc_reg == CW'(V_TOTAL - 1));
    at_origin = (hc_reg == '0) && (vc_reg == '0);
    hc_next   = h_last ? '0 : hc_reg + 1'b1;
    vc_next   = vc_reg;
    if (h_last) begin
      vc_next = v_last ? '0 : vc_reg + 1'b1;
    end
    h_in_sync = (hc_reg >= CW'(H_ACTIVE + H_FP)) && (hc_reg < CW'(H_ACTIVE + H_FP + H_SYNC));
    v_in_sync = (vc_reg >= CW'(V_ACTIVE + V_FP)) && (vc_reg < CW'(V_ACTIVE + V_FP + V_SYNC));
    active    = (hc_reg < CW'(H_ACTIVE)) && (vc_reg < CW'(V_ACTIVE));
  end

  // One-hot bar decode of the stage-1 column; the last bar absorbs any remainder.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bar
      if (gi == 0) begin : g_first
        assign bar_hit[gi] = (pix_x_reg < CW'(BAR_W));
      end else if (gi == 7) begin : g_last
        assign bar_hit[gi] = (pix_x_reg >= CW'(gi * BAR_W));
      end else begin : g_mid
        assign bar_hit[gi] = (pix_x_reg >= CW'(gi * BAR_W)) &&
                             (pix_x_reg < CW'((gi + 1) * BAR_W));
      end
    end
  endgenerate

  always_comb begin
    rgb_next = 12'h000;
    if (pix_req_reg) begin
      unique case (mode_reg)
        2'd0: rgb_next = pix_rgb;
        2'd1: rgb_next = 12'hF00;
        2'd2: begin
          for (int i = 0; i < 8; i++) begin
            if (bar_hit[i]) rgb_next = BAR_RGB[i];
          end
        end
        default: begin
          if ((pix_x_reg[4:0] == 5'd0) || (pix_y_reg[4:0] == 5'd0)) rgb_next = 12'hFFF;
        end
      endcase
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!reset_n) begin
      div_reg         <= '0;
      hc_reg          <= '0;
      vc_reg          <= '0;
      mode_reg        <= mode;
      pix_req_reg     <= 1'b0;
      pix_x_reg       <= '0;
      pix_y_reg       <= '0;
      hs1_reg         <= 1'b0;
      vs1_reg         <= 1'b0;
      hs_reg          <= ~H_POL;
      vs_reg          <= ~V_POL;
      rgb_reg         <= 12'h000;
      frame_start_reg <= 1'b0;
    end else begin
      div_reg         <= div_next;
      frame_start_reg <= 1'b0;
      if (tick) begin
        hc_reg      <= hc_next;
        vc_reg      <= vc_next;
        // Mode only changes at the frame origin so a frame is never torn.
        if (at_origin) begin
          mode_reg        <= mode;
          frame_start_reg <= 1'b1;
        end
        pix_req_reg <= active;
        pix_x_reg   <= hc_reg;
        pix_y_reg   <= vc_reg;
        hs1_reg     <= h_in_sync;
        vs1_reg     <= v_in_sync;
        hs_reg      <= hs1_reg ? H_POL : ~H_POL;
        vs_reg      <= vs1_reg ? V_POL : ~V_POL;
        rgb_reg     <= rgb_next;
      end
    end
  end

  assign pix_req     = pix_req_reg;
  assign pix_x       = pix_x_reg;
  assign pix_y       = pix_y_reg;
  assign VGA_HS      = hs_reg;
  assign VGA_VS      = vs_reg;
  assign {VGA_R, VGA_G, VGA_B} = rgb_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: reduced-size timings, a cycle-level reference model of instance A,
// table-driven pixel vectors, period/width measurements and reset / mode-change sequences.
module tb_vga_timing_gen;

  // Instance A: small frame, positive syncs, one pixel per clock.
  localparam int HA_A = 64, HF_A = 4, HS_A = 8, HB_A = 4;
  localparam int VA_A = 8,  VF_A = 2, VS_A = 2, VB_A = 2;
  localparam int HT_A = HA_A + HF_A + HS_A + HB_A;   // 80
  localparam int VT_A = VA_A + VF_A + VS_A + VB_A;   // 14
  localparam int FR_A = HT_A * VT_A;                 // 1120
  // Instance B: negative syncs, two clocks per pixel.
  localparam int HA_B = 32, HF_B = 4, HS_B = 6, HB_B = 2;
  localparam int VA_B = 6,  VF_B = 1, VS_B = 2, VB_B = 1;
  localparam int HT_B = HA_B + HF_B + HS_B + HB_B;   // 44
  localparam int VT_B = VA_B + VF_B + VS_B + VB_B;   // 10
  localparam int DIV_B = 2;
  localparam int LIM = 4000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] mode = 2'd1;

  logic        req_a, fs_a, hs_a, vs_a;
  logic [7:0]  x_a, y_a;
  logic [3:0]  r_a, g_a, b_a;
  logic [11:0] rgb_in_a;
  logic        req_b, fs_b, hs_b, vs_b;
  logic [5:0]  x_b, y_b;
  logic [3:0]  r_b, g_b, b_b;
  logic [11:0] rgb_in_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Framebuffer stub: data for the requested coordinate, held while the request is held.
  assign rgb_in_a = {x_a[3:0], y_a[3:0], 4'h5};
  assign rgb_in_b = 12'hABC;

  vga_timing_gen #(
    .H_ACTIVE(HA_A), .H_FP(HF_A), .H_SYNC(HS_A), .H_BP(HB_A),
    .V_ACTIVE(VA_A), .V_FP(VF_A), .V_SYNC(VS_A), .V_BP(VB_A),
    .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .CW(8)
  ) dut_a (
    .MAX10_CLK1_50(clk), .reset_n(reset_n), .mode(mode),
    .pix_req(req_a), .pix_x(x_a), .pix_y(y_a), .pix_rgb(rgb_in_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .VGA_HS(hs_a), .VGA_VS(vs_a),
    .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA_B), .H_FP(HF_B), .H_SYNC(HS_B), .H_BP(HB_B),
    .V_ACTIVE(VA_B), .V_FP(VF_B), .V_SYNC(VS_B), .V_BP(VB_B),
    .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(DIV_B), .CW(6)
  ) dut_b (
    .MAX10_CLK1_50(clk), .reset_n(reset_n), .mode(mode),
    .pix_req(req_b), .pix_x(x_b), .pix_y(y_b), .pix_rgb(rgb_in_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .VGA_HS(hs_b), .VGA_VS(vs_b),
    .frame_start(fs_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model of instance A ----------------
  // Pixel n of the raster stream (n = 0 at the first tick after reset) is at
  // column n mod H_TOTAL, row (n / H_TOTAL) mod V_TOTAL.
  function automatic int col_of(int n); return n % HT_A; endfunction
  function automatic int row_of(int n); return (n / HT_A) % VT_A; endfunction
  function automatic bit vis(int n);
    return (col_of(n) < HA_A) && (row_of(n) < VA_A);
  endfunction

  function automatic logic [11:0] ref_colour(int m, int x, int y);
    case (m)
      0: return {4'(x % 16), 4'(y % 16), 4'h5};
      1: return 12'hF00;
      2: begin
        case (x / (HA_A / 8))
          0: return 12'hFFF;
          1: return 12'hFF0;
          2: return 12'h0FF;
          3: return 12'h0F0;
          4: return 12'hF0F;
          5: return 12'hF00;
          6: return 12'h00F;
          default: return 12'h000;
        endcase
      end
      default: return ((x % 32) == 0 || (y % 32) == 0) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  int e_a = -1;            // ticks since reset release minus one; -1 while in reset
  int frame_mode [int];    // mode in force for each frame number
  bit model_on = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      e_a = -1;
    end else begin
      e_a++;
      if (e_a % FR_A == 0) frame_mode[e_a / FR_A] = int'(mode);
    end
  end

  always @(negedge clk) begin
    logic [17:0] exp1, act1;
    logic [13:0] exp2, act2;
    int q, hx, vy;
    if (model_on) begin
      if (e_a < 0) begin
        exp1 = '0;
      end else begin
        exp1 = {vis(e_a), (e_a % FR_A) == 0,
                vis(e_a) ? 8'(col_of(e_a)) : 8'h00, vis(e_a) ? 8'(row_of(e_a)) : 8'h00};
      end
      act1 = {req_a, fs_a, req_a ? x_a : 8'h00, req_a ? y_a : 8'h00};
      check("model_stage1", 64'(act1), 64'(exp1));
      if (e_a < 1) begin
        exp2 = '0;
      end else begin
        q  = e_a - 1;
        hx = col_of(q);
        vy = row_of(q);
        exp2 = {(hx >= HA_A + HF_A) && (hx < HA_A + HF_A + HS_A),
                (vy >= VA_A + VF_A) && (vy < VA_A + VF_A + VS_A),
                vis(q) ? ref_colour(frame_mode[q / FR_A], hx, vy) : 12'h000};
      end
      act2 = {hs_a, vs_a, r_a, g_a, b_a};
      check("model_pins", 64'(act2), 64'(exp2));
    end
  end

  // ---------------- helpers ----------------
  function automatic bit sample(int w);
    case (w)
      0: return hs_a;
      1: return vs_a;
      2: return fs_a;
      3: return ~hs_b;
      4: return ~vs_b;
      default: return fs_b;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Width (clocks active) and period (clocks between rising edges) of an active-high view.
  task automatic measure(input int w, output int width, output int period);
    int n;
    width = -1;
    period = -1;
    n = 0;
    while (sample(w) && n < LIM * 2) begin step(); n++; end
    n = 0;
    while (!sample(w) && n < LIM) begin step(); n++; end
    if (n >= LIM) return;
    width = 0;
    period = 0;
    while (sample(w) && width < LIM) begin step(); width++; period++; end
    while (!sample(w) && period < LIM) begin step(); period++; end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * FR_A; i++) begin
      step();
      if (fs_a) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  typedef struct {
    logic [1:0]  m;
    int          x;
    int          y;
    logic [11:0] rgb;
    logic        hs;
  } vec_t;

  vec_t vec [15];

  initial begin
    int w, p;
    bit ok;

    vec[0]  = '{2'd1,  5, 5, 12'hF00, 1'b0};
    vec[1]  = '{2'd1, 63, 7, 12'hF00, 1'b0};
    vec[2]  = '{2'd1, 64, 7, 12'h000, 1'b0};
    vec[3]  = '{2'd1, 70, 2, 12'h000, 1'b1};
    vec[4]  = '{2'd2,  0, 0, 12'hFFF, 1'b0};
    vec[5]  = '{2'd2,  7, 3, 12'hFFF, 1'b0};
    vec[6]  = '{2'd2,  8, 3, 12'hFF0, 1'b0};
    vec[7]  = '{2'd2, 63, 3, 12'h000, 1'b0};
    vec[8]  = '{2'd2, 40, 1, 12'hF00, 1'b0};
    vec[9]  = '{2'd3, 32, 5, 12'hFFF, 1'b0};
    vec[10] = '{2'd3, 33, 5, 12'h000, 1'b0};
    vec[11] = '{2'd3,  3, 0, 12'hFFF, 1'b0};
    vec[12] = '{2'd0,  5, 3, 12'h535, 1'b0};
    vec[13] = '{2'd0, 12, 7, 12'hC75, 1'b0};
    vec[14] = '{2'd0, 67, 0, 12'h000, 1'b0};

    // Reset state.
    repeat (2) step();
    model_on = 1'b1;
    check("reset_a", {req_a, fs_a, x_a, y_a, r_a, g_a, b_a, hs_a, vs_a}, '0);
    check("reset_b", {hs_b, vs_b, req_b, fs_b}, 4'b1100);
    reset_n = 1'b1;
    step();
    check("first_fs_a", fs_a, 1'b1);
    $display("reset released, frame_start_a=%0b", fs_a);

    // Sync and frame timing, mode 1.
    measure(0, w, p);
    check("hs_a_width", w, HS_A);
    check("hs_a_period", p, HT_A);
    $display("A hsync width=%0d period=%0d", w, p);
    measure(1, w, p);
    check("vs_a_width", w, VS_A * HT_A);
    check("vs_a_period", p, FR_A);
    $display("A vsync width=%0d period=%0d", w, p);
    measure(2, w, p);
    check("fs_a_width", w, 1);
    check("fs_a_period", p, FR_A);
    measure(3, w, p);
    check("hs_b_low_width", w, HS_B * DIV_B);
    check("hs_b_period", p, HT_B * DIV_B);
    $display("B hsync low width=%0d period=%0d", w, p);
    measure(4, w, p);
    check("vs_b_low_width", w, VS_B * HT_B * DIV_B);
    measure(5, w, p);
    check("fs_b_width", w, 1);
    check("fs_b_period", p, HT_B * VT_B * DIV_B);
    $display("B frame_start width=%0d period=%0d", w, p);

    // Table of pixel vectors: select mode, wait for the frame it applies to, read the pin pixel.
    foreach (vec[i]) begin
      mode = vec[i].m;
      wait_fs(ok);
      check("vec_fs_wait", ok, 1'b1);
      repeat (vec[i].y * HT_A + vec[i].x + 1) step();
      check($sformatf("vec%0d", i), {hs_a, r_a, g_a, b_a}, {vec[i].hs, vec[i].rgb});
      $display("vec %0d mode=%0d pixel(%0d,%0d) rgb=%h%h%h hs=%0b",
               i, vec[i].m, vec[i].x, vec[i].y, r_a, g_a, b_a, hs_a);
    end

    // Mode 1 -> 3 mid-frame: current frame stays red, grid from next frame_start.
    mode = 2'd1;
    wait_fs(ok);
    check("mc_fs_wait", ok, 1'b1);
    repeat (100) step();
    mode = 2'd3;
    repeat (5 * HT_A + 33 + 1 - 100) step();
    check("mc_red_hold", {r_a, g_a, b_a}, 12'hF00);
    wait_fs(ok);
    check("mc_fs_wait2", ok, 1'b1);
    repeat (5 * HT_A + 32 + 1) step();
    check("mc_grid_32_5", {r_a, g_a, b_a}, 12'hFFF);
    step();
    check("mc_grid_33_5", {r_a, g_a, b_a}, 12'h000);
    $display("mode change 1->3 done, pixel(33,5)=%h%h%h", r_a, g_a, b_a);

    // Reset for 3 clocks mid-line.
    mode = 2'd1;
    wait_fs(ok);
    repeat (HT_A + 30) step();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_hold_a", {req_a, fs_a, x_a, y_a, r_a, g_a, b_a, hs_a, vs_a}, '0);
      check("rst_hold_b", {hs_b, vs_b, req_b, fs_b, r_b, g_b, b_b}, {4'b1100, 12'h000});
    end
    reset_n = 1'b1;
    step();
    check("rst_fs_a_edge0", {fs_a, fs_b}, 2'b10);
    step();
    check("rst_fs_edge1", {fs_a, fs_b}, 2'b01);
    measure(0, w, p);
    check("rst_hs_a_width", w, HS_A);
    check("rst_hs_a_period", p, HT_A);
    $display("after mid-line reset hsync width=%0d period=%0d", w, p);

    // Randomized mode changes checked against the model.
    for (int i = 0; i < 12; i++) begin
      mode = 2'($urandom_range(0, 3));
      repeat ($urandom_range(50, 1500)) step();
      $display("random %0d mode=%0d pixel stream index=%0d", i, mode, e_a);
    end

    model_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
